// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and default parameters for the pipeline hazard controller.
package pipeline_ctrl_pkg;

    localparam int unsigned ADDR_W_DEF       = 5;
    localparam int unsigned CNT_W_DEF        = 16;
    localparam int unsigned MISS_TIMEOUT_DEF = 1024;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_MISS    = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_bubble;
        logic ex_mem_write;
        logic mem_wb_write;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_HOLD = '{default: 1'b0};
    localparam stage_ctrl_t CTRL_FLOW = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                          id_ex_bubble: 1'b0, ex_mem_write: 1'b1, mem_wb_write: 1'b1};

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use compare between the load in EX and the sources in ID.
module hazard_detect
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              mem_read_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [ADDR_W-1:0] rs1_addr_i,
    input  logic [ADDR_W-1:0] rs2_addr_i,
    output logic              load_use_o
);

    // x0 is hardwired to zero, so a load into it never creates a dependency
    always_comb begin
        load_use_o = mem_read_i && (rd_addr_i != '0) &&
                     ((rd_addr_i == rs1_addr_i) || (rd_addr_i == rs2_addr_i));
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: run/miss FSM, zero-latency stage controls,
// saturating hazard statistics and a sticky cache-stall timeout.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned MISS_TIMEOUT = MISS_TIMEOUT_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              ID_EX_MemRead_i,
    input  logic [ADDR_W-1:0] ID_EX_RDaddr_i,
    input  logic [ADDR_W-1:0] IF_ID_RS1addr_i,
    input  logic [ADDR_W-1:0] IF_ID_RS2addr_i,
    input  logic              branch_taken_i,
    input  logic              dcache_stall_i,
    output logic              PC_write_o,
    output logic              IF_ID_write_o,
    output logic              IF_ID_flush_o,
    output logic              ID_EX_bubble_o,
    output logic              EX_MEM_write_o,
    output logic              MEM_WB_write_o,
    output logic [1:0]        state_o,
    output logic [CNT_W-1:0]  loaduse_cnt_o,
    output logic [CNT_W-1:0]  miss_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o,
    output logic              timeout_o
);

    localparam int unsigned STALL_W = $clog2(MISS_TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   loaduse_cnt_q, loaduse_cnt_d;
    logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic [STALL_W-1:0] stall_run_q, stall_run_d;
    logic               timeout_q, timeout_d;

    logic        load_use;
    logic        active;
    logic        stall_hit;
    logic        loaduse_hit;
    logic        flush_hit;
    stage_ctrl_t ctrl;

    hazard_detect #(.ADDR_W(ADDR_W)) u_hazard_detect (
        .mem_read_i (ID_EX_MemRead_i),
        .rd_addr_i  (ID_EX_RDaddr_i),
        .rs1_addr_i (IF_ID_RS1addr_i),
        .rs2_addr_i (IF_ID_RS2addr_i),
        .load_use_o (load_use)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_i) state_d = ST_RUN;
            ST_RUN: begin
                if (!start_i)            state_d = ST_IDLE;
                else if (dcache_stall_i) state_d = ST_MISS;
            end
            ST_MISS: begin
                if (!start_i)             state_d = ST_IDLE;
                else if (!dcache_stall_i) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stage controls: cache stall outranks load-use, which outranks branch flush
    always_comb begin
        active      = (state_q == ST_RUN) || (state_q == ST_MISS);
        stall_hit   = active && dcache_stall_i;
        loaduse_hit = active && !dcache_stall_i && load_use;
        flush_hit   = active && !dcache_stall_i && !load_use && branch_taken_i;
        ctrl        = CTRL_HOLD;
        if (active && !stall_hit) begin
            ctrl = CTRL_FLOW;
            if (loaduse_hit) begin
                ctrl.pc_write     = 1'b0;
                ctrl.if_id_write  = 1'b0;
                ctrl.id_ex_bubble = 1'b1;
            end else if (flush_hit) begin
                ctrl.if_id_flush  = 1'b1;
            end
        end
    end

    // Statistics and consecutive-stall tracking
    always_comb begin
        loaduse_cnt_d = loaduse_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        stall_run_d   = '0;
        timeout_d     = timeout_q;
        if (loaduse_hit && (loaduse_cnt_q != '1)) loaduse_cnt_d = loaduse_cnt_q + CNT_W'(1);
        if (stall_hit && (miss_cnt_q != '1))      miss_cnt_d    = miss_cnt_q + CNT_W'(1);
        if (flush_hit && (flush_cnt_q != '1))     flush_cnt_d   = flush_cnt_q + CNT_W'(1);
        if (state_q == ST_MISS) begin
            stall_run_d = stall_run_q;
            if (stall_run_q != STALL_W'(MISS_TIMEOUT)) stall_run_d = stall_run_q + STALL_W'(1);
            if (stall_run_q >= STALL_W'(MISS_TIMEOUT - 1)) timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            loaduse_cnt_q <= '0;
            miss_cnt_q    <= '0;
            flush_cnt_q   <= '0;
            stall_run_q   <= '0;
            timeout_q     <= 1'b0;
        end else begin
            loaduse_cnt_q <= loaduse_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            stall_run_q   <= stall_run_d;
            timeout_q     <= timeout_d;
        end
    end

    assign PC_write_o     = ctrl.pc_write;
    assign IF_ID_write_o  = ctrl.if_id_write;
    assign IF_ID_flush_o  = ctrl.if_id_flush;
    assign ID_EX_bubble_o = ctrl.id_ex_bubble;
    assign EX_MEM_write_o = ctrl.ex_mem_write;
    assign MEM_WB_write_o = ctrl.mem_wb_write;
    assign state_o        = state_q;
    assign loaduse_cnt_o  = loaduse_cnt_q;
    assign miss_cnt_o     = miss_cnt_q;
    assign flush_cnt_o    = flush_cnt_q;
    assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus a
// randomized run scored against a behavioural model of the control rules.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned CNT_W  = 6;
    localparam int unsigned TMO    = 4;
    localparam int          CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_i = 1'b0;
    logic              start_i = 1'b0;
    logic              mr_i = 1'b0;
    logic [ADDR_W-1:0] rd_i = '0, rs1_i = '0, rs2_i = '0;
    logic              br_i = 1'b0;
    logic              st_i = 1'b0;
    logic              pc_o, ifid_o, flush_o, bub_o, exmem_o, memwb_o;
    logic [1:0]        state_o;
    logic [CNT_W-1:0]  lu_cnt_o, miss_cnt_o, fl_cnt_o;
    logic              tmo_o;

    int compared = 0;
    int mismatched = 0;

    // Behavioural model
    int m_state, m_lu, m_miss, m_fl, m_run;
    bit m_tmo;

    pipeline_hazard_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .MISS_TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .ID_EX_MemRead_i(mr_i), .ID_EX_RDaddr_i(rd_i),
        .IF_ID_RS1addr_i(rs1_i), .IF_ID_RS2addr_i(rs2_i),
        .branch_taken_i(br_i), .dcache_stall_i(st_i),
        .PC_write_o(pc_o), .IF_ID_write_o(ifid_o), .IF_ID_flush_o(flush_o),
        .ID_EX_bubble_o(bub_o), .EX_MEM_write_o(exmem_o), .MEM_WB_write_o(memwb_o),
        .state_o(state_o), .loaduse_cnt_o(lu_cnt_o), .miss_cnt_o(miss_cnt_o),
        .flush_cnt_o(fl_cnt_o), .timeout_o(tmo_o)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] ctrl_obs();
        return {pc_o, ifid_o, flush_o, bub_o, exmem_o, memwb_o};
    endfunction

    function automatic bit model_lu();
        return mr_i && (rd_i != 0) && ((rd_i == rs1_i) || (rd_i == rs2_i));
    endfunction

    // {pc, if_id, flush, bubble, ex_mem, mem_wb}
    function automatic logic [5:0] model_ctrl();
        if (!(m_state == 1 || m_state == 2)) return 6'b000000;
        if (st_i)                            return 6'b000000;
        if (model_lu())                      return 6'b000111;
        if (br_i)                            return 6'b111011;
        return 6'b110011;
    endfunction

    function automatic int sat_inc(input int v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    task automatic model_step();
        bit act;
        if (!rst_i) begin
            m_state = 0; m_lu = 0; m_miss = 0; m_fl = 0; m_run = 0; m_tmo = 0;
            return;
        end
        act = (m_state == 1 || m_state == 2);
        if (act && st_i)                    m_miss = sat_inc(m_miss);
        else if (act && model_lu())         m_lu   = sat_inc(m_lu);
        else if (act && br_i)               m_fl   = sat_inc(m_fl);
        if (m_state == 2) begin
            m_run++;
            if (m_run >= TMO) m_tmo = 1;
        end else begin
            m_run = 0;
        end
        case (m_state)
            0: if (start_i) m_state = 1;
            1: if (!start_i) m_state = 0; else if (st_i) m_state = 2;
            2: if (!start_i) m_state = 0; else if (!st_i) m_state = 1;
            default: m_state = 0;
        endcase
    endtask

    task automatic drive(input logic rst, input logic start, input logic mr,
                         input int rd, input int rs1, input int rs2,
                         input logic br, input logic st);
        @(negedge clk);
        rst_i = rst; start_i = start; mr_i = mr;
        rd_i = ADDR_W'(rd); rs1_i = ADDR_W'(rs1); rs2_i = ADDR_W'(rs2);
        br_i = br; st_i = st;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        drive(0, 1, 1, 5, 5, 5, 1, 1); tick();
        drive(0, 1, 1, 5, 5, 5, 1, 1); tick();
    endtask

    task automatic enter_run();
        do_reset();
        drive(1, 1, 0, 0, 0, 0, 0, 0); tick();
    endtask

    task automatic test_reset();
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        compared++;
        if (ctrl_obs() !== 6'b000000) begin
            mismatched++; $display("FAIL reset_ctrl got=%b want=000000", ctrl_obs());
        end
        tick();
        compared++;
        if (state_o !== 2'd0 || lu_cnt_o !== 0 || miss_cnt_o !== 0 || fl_cnt_o !== 0 || tmo_o !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_regs got state=%0d lu=%0d miss=%0d fl=%0d tmo=%b want all 0",
                     state_o, lu_cnt_o, miss_cnt_o, fl_cnt_o, tmo_o);
        end
    endtask

    task automatic test_loaduse();
        enter_run();
        compared++;
        if (state_o !== 2'd1) begin mismatched++; $display("FAIL lu_run_state got=%0d want=1", state_o); end
        drive(1, 1, 1, 5, 3, 5, 0, 0);
        compared++;
        if (ctrl_obs() !== 6'b000111) begin
            mismatched++; $display("FAIL lu_ctrl got=%b want=000111", ctrl_obs());
        end
        tick();
        compared++;
        if (lu_cnt_o !== 6'd1) begin mismatched++; $display("FAIL lu_cnt got=%0d want=1", lu_cnt_o); end
    endtask

    task automatic test_rd_zero();
        enter_run();
        drive(1, 1, 1, 0, 0, 7, 0, 0);
        compared++;
        if (ctrl_obs() !== 6'b110011) begin
            mismatched++; $display("FAIL rd0_ctrl got=%b want=110011", ctrl_obs());
        end
        tick();
        compared++;
        if (lu_cnt_o !== 6'd0) begin mismatched++; $display("FAIL rd0_cnt got=%0d want=0", lu_cnt_o); end
    endtask

    task automatic test_branch_priority();
        enter_run();
        drive(1, 1, 1, 9, 9, 2, 1, 0);
        compared++;
        if (ctrl_obs() !== 6'b000111) begin
            mismatched++; $display("FAIL br_lu_ctrl got=%b want=000111", ctrl_obs());
        end
        tick();
        compared++;
        if (fl_cnt_o !== 6'd0 || lu_cnt_o !== 6'd1) begin
            mismatched++; $display("FAIL br_lu_cnt got fl=%0d lu=%0d want fl=0 lu=1", fl_cnt_o, lu_cnt_o);
        end
        drive(1, 1, 0, 9, 9, 2, 1, 0);
        compared++;
        if (ctrl_obs() !== 6'b111011) begin
            mismatched++; $display("FAIL br_ctrl got=%b want=111011", ctrl_obs());
        end
        tick();
        compared++;
        if (fl_cnt_o !== 6'd1) begin mismatched++; $display("FAIL br_cnt got=%0d want=1", fl_cnt_o); end
    endtask

    task automatic test_miss();
        enter_run();
        for (int i = 1; i <= 3; i++) begin
            drive(1, 1, 1, 4, 4, 4, 1, 1);
            compared++;
            if (ctrl_obs() !== 6'b000000) begin
                mismatched++; $display("FAIL miss_ctrl cyc=%0d got=%b want=000000", i, ctrl_obs());
            end
            tick();
            compared++;
            if (state_o !== 2'd2 || miss_cnt_o !== CNT_W'(i)) begin
                mismatched++;
                $display("FAIL miss_regs cyc=%0d got state=%0d cnt=%0d want state=2 cnt=%0d", i, state_o, miss_cnt_o, i);
            end
        end
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        compared++;
        if (ctrl_obs() !== 6'b110011) begin
            mismatched++; $display("FAIL miss_exit_ctrl got=%b want=110011", ctrl_obs());
        end
        tick();
        compared++;
        if (state_o !== 2'd1 || tmo_o !== 1'b0 || miss_cnt_o !== 6'd3) begin
            mismatched++;
            $display("FAIL miss_exit got state=%0d tmo=%b cnt=%0d want state=1 tmo=0 cnt=3", state_o, tmo_o, miss_cnt_o);
        end
    endtask

    task automatic test_timeout_reset();
        enter_run();
        for (int k = 1; k <= 5; k++) begin
            drive(1, 1, 0, 0, 0, 0, 0, 1);
            tick();
            compared++;
            if (tmo_o !== ((k >= TMO + 1) ? 1'b1 : 1'b0) || state_o !== 2'd2) begin
                mismatched++;
                $display("FAIL tmo_rise cyc=%0d got tmo=%b state=%0d want tmo=%b state=2",
                         k, tmo_o, state_o, (k >= TMO + 1));
            end
        end
        drive(0, 1, 0, 0, 0, 0, 0, 1);
        tick();
        compared++;
        if (state_o !== 2'd0 || tmo_o !== 1'b0 || miss_cnt_o !== 6'd0) begin
            mismatched++;
            $display("FAIL tmo_reset got state=%0d tmo=%b miss=%0d want 0 0 0", state_o, tmo_o, miss_cnt_o);
        end
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        compared++;
        if (ctrl_obs() !== 6'b000000) begin
            mismatched++; $display("FAIL post_rst_idle got=%b want=000000", ctrl_obs());
        end
        tick();
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        compared++;
        if (state_o !== 2'd1 || ctrl_obs() !== 6'b110011) begin
            mismatched++;
            $display("FAIL post_rst_run got state=%0d ctrl=%b want state=1 ctrl=110011", state_o, ctrl_obs());
        end
        tick();
    endtask

    task automatic test_saturation();
        enter_run();
        for (int i = 0; i < CMAX + 8; i++) begin
            drive(1, 1, 1, 6, 6, 1, 0, 0);
            tick();
        end
        compared++;
        if (lu_cnt_o !== CNT_W'(CMAX) || state_o !== 2'd1) begin
            mismatched++;
            $display("FAIL lu_saturate got cnt=%0d state=%0d want cnt=%0d state=1", lu_cnt_o, state_o, CMAX);
        end
    endtask

    task automatic test_random();
        logic [5:0] exp_c;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 99) >= 3), ($urandom_range(0, 99) < 92),
                  $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), ($urandom_range(0, 99) < 30),
                  ($urandom_range(0, 99) < 35));
            exp_c = model_ctrl();
            compared++;
            if (ctrl_obs() !== exp_c) begin
                mismatched++; $display("FAIL rnd_ctrl i=%0d got=%b want=%b", i, ctrl_obs(), exp_c);
            end
            tick();
            compared++;
            if (state_o !== 2'(m_state) || tmo_o !== m_tmo) begin
                mismatched++;
                $display("FAIL rnd_fsm i=%0d got state=%0d tmo=%b want state=%0d tmo=%b",
                         i, state_o, tmo_o, m_state, m_tmo);
            end
            compared++;
            if (lu_cnt_o !== CNT_W'(m_lu) || miss_cnt_o !== CNT_W'(m_miss) || fl_cnt_o !== CNT_W'(m_fl)) begin
                mismatched++;
                $display("FAIL rnd_cnt i=%0d got lu=%0d miss=%0d fl=%0d want lu=%0d miss=%0d fl=%0d",
                         i, lu_cnt_o, miss_cnt_o, fl_cnt_o, m_lu, m_miss, m_fl);
            end
        end
    endtask

    initial begin
        m_state = 0; m_lu = 0; m_miss = 0; m_fl = 0; m_run = 0; m_tmo = 0;
        test_reset();
        test_loaduse();
        test_rd_zero();
        test_branch_priority();
        test_miss();
        test_timeout_reset();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
